// File: rtl/encoder_pkg.sv
// encoder_pkg: shared mode codes, register offsets and Gray step decode for the encoder bank
package encoder_pkg;
  localparam logic [1:0] MODE_X4 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X1 = 2'd2;
  localparam logic [1:0] MODE_OFF = 2'd3;
  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_UP = 2'b01;
  localparam logic [1:0] STEP_DN = 2'b11;
  function automatic int CHANGED_ADDR(int n);
    return n;
  endfunction
  function automatic int MODE_ADDR(int n);
    return n + 1;
  endfunction
  // Forward Gray order is 00->01->11->10->00; double-bit jumps decode as no step
  function automatic logic [1:0] step_dir(logic [1:0] p, logic [1:0] n);
    case ({p, n})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return STEP_UP;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return STEP_DN;
      default: return STEP_NONE;
    endcase
  endfunction
endpackage

// File: rtl/quad_channel.sv
// quad_channel: one encoder channel with synchroniser, debounce, decode and position counter
module quad_channel
  import encoder_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byte_en,
  output logic [POS_W-1:0] pos,
  output logic             step
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  logic [1:0] s1, s2, deb, prev, dir;
  logic [CW-1:0] cnt;
  logic [POS_W-1:0] wpos;
  logic unused;
  assign unused = ^{wdata, byte_en};
  // Decode the debounced transition and filter it by counting mode
  always_comb begin
    dir = step_dir(prev, deb);
    step = dir != STEP_NONE && (mode == MODE_X4 || (mode == MODE_X2 && deb[1] == deb[0]) || (mode == MODE_X1 && deb == 2'b00));
  end
  // Byte-lane merge of a register write into the current position
  always_comb begin
    wpos = pos;
    for (int i = 0; i < POS_W; i++) wpos[i] = byte_en[i/8] ? wdata[i] : pos[i];
  end
  // Two-flop synchroniser and stability filter; a change of the synced value restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
      deb <= 2'b00;
      prev <= 2'b00;
      cnt <= '0;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
      prev <= deb;
      if (s2 == deb) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else cnt <= (s1 != s2) ? '0 : cnt + 1'b1;
    end
  end
  // Position counter; a register write overrides a coincident step
  always_ff @(posedge clk) begin
    if (rst) pos <= '0;
    else if (we) pos <= wpos;
    else if (step) pos <= (dir == STEP_UP) ? pos + 1'b1 : pos - 1'b1;
  end
endmodule

// File: rtl/encoder_bank.sv
// encoder_bank: bank of quadrature encoder channels behind a 32-bit register port
module encoder_bank
  import encoder_pkg::*;
#(
  parameter int NUM_ENC = 8,
  parameter int POS_W = 16,
  parameter int DEBOUNCE = 4,
  parameter int ADDR_W = $clog2(NUM_ENC + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        reg_we,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_data,
  output logic [31:0]       reg_q,
  input  logic [NUM_ENC-1:0] enc_a,
  input  logic [NUM_ENC-1:0] enc_b
);
  localparam int MW = 2 * NUM_ENC;
  logic [NUM_ENC-1:0] steps, changed, clr;
  logic [MW-1:0] mode, mode_n;
  logic [31:0] pos_ext [NUM_ENC];
  for (genvar k = 0; k < NUM_ENC; k++) begin : g_ch
    logic [POS_W-1:0] pos;
    quad_channel #(.POS_W(POS_W), .DEBOUNCE(DEBOUNCE)) u_ch (
      .clk(clk),
      .rst(rst),
      .a(enc_a[k]),
      .b(enc_b[k]),
      .mode(mode[2*k+:2]),
      .we(|reg_we && reg_addr == ADDR_W'(k)),
      .wdata(reg_data),
      .byte_en(reg_we),
      .pos(pos),
      .step(steps[k])
    );
    assign pos_ext[k] = 32'(pos);
  end
  // Write-1-to-clear mask for CHANGED and byte-lane merge for MODE
  always_comb begin
    clr = '0;
    mode_n = mode;
    for (int i = 0; i < NUM_ENC; i++) clr[i] = reg_addr == ADDR_W'(CHANGED_ADDR(NUM_ENC)) && reg_we[i/8] && reg_data[i];
    for (int i = 0; i < MW; i++) mode_n[i] = (reg_addr == ADDR_W'(MODE_ADDR(NUM_ENC)) && reg_we[i/8]) ? reg_data[i] : mode[i];
  end
  // Control registers; a new count beats a concurrent clear
  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= '0;
      mode <= '0;
    end else begin
      changed <= (changed & ~clr) | steps;
      mode <= mode_n;
    end
  end
  // Read mux; unmapped addresses read zero
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_ENC; i++) if (reg_addr == ADDR_W'(i)) reg_q = pos_ext[i];
    if (reg_addr == ADDR_W'(CHANGED_ADDR(NUM_ENC))) reg_q = 32'(changed);
    if (reg_addr == ADDR_W'(MODE_ADDR(NUM_ENC))) reg_q = 32'(mode);
  end
endmodule

// File: tb/tb_encoder_bank.sv
// tb_encoder_bank: table-driven and scoreboard checks of the encoder bank
module tb_encoder_bank;
  localparam int N = 8;
  localparam int W = 16;
  localparam int D = 4;
  localparam int AW = $clog2(N + 2);
  typedef struct {
    logic [31:0] val;
    int edge_n;
  } sb_t;
  typedef struct {
    logic [1:0] mode;
    logic rev;
    logic [31:0] pos;
    logic [31:0] chg;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] reg_we = 0;
  logic [AW-1:0] reg_addr = 0;
  logic [31:0] reg_data = 0;
  logic [31:0] reg_q;
  logic [N-1:0] enc_a = 0;
  logic [N-1:0] enc_b = 0;
  int ecnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 0;
  logic [31:0] last_q = 0;
  sb_t sbq[$];
  logic [1:0] m_deb[N];
  logic [W-1:0] m_pos[N];
  logic [1:0] m_mode[N];
  logic [N-1:0] m_chg;
  vec_t vt[7];

  encoder_bank #(.NUM_ENC(N), .POS_W(W), .DEBOUNCE(D)) dut (
    .clk(clk),
    .rst(rst),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .reg_q(reg_q),
    .enc_a(enc_a),
    .enc_b(enc_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int gidx(logic [1:0] v);
    return v == 2'b00 ? 0 : v == 2'b01 ? 1 : v == 2'b11 ? 2 : 3;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one channel's pins to a new level and predict the resulting count
  task automatic drive_level(input int ch, input logic [1:0] lvl);
    int di;
    logic ok;
    enc_a[ch] = lvl[1];
    enc_b[ch] = lvl[0];
    di = (gidx(lvl) - gidx(m_deb[ch]) + 4) % 4;
    ok = (di == 1 || di == 3) && (m_mode[ch] == 2'd0 || (m_mode[ch] == 2'd1 && (lvl == 2'b00 || lvl == 2'b11)) || (m_mode[ch] == 2'd2 && lvl == 2'b00));
    if (ok) begin
      m_pos[ch] = (di == 1) ? m_pos[ch] + W'(1) : m_pos[ch] - W'(1);
      m_chg[ch] = 1'b1;
      if (mon_en && ch == 0) sbq.push_back('{32'(m_pos[ch]), ecnt + D + 3});
    end
    m_deb[ch] = lvl;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] we);
    reg_addr = AW'(a);
    reg_data = d;
    reg_we = we;
    tick(1);
    reg_we = 0;
  endtask

  task automatic rd(input string name, input int a, input logic [31:0] exp);
    reg_addr = AW'(a);
    #1;
    chk(name, reg_q, exp);
  endtask

  task automatic do_reset(input logic [1:0] pins);
    mon_en = 0;
    enc_a = {N{pins[1]}};
    enc_b = {N{pins[0]}};
    rst = 1;
    tick(3);
    rst = 0;
    for (int k = 0; k < N; k++) begin
      m_pos[k] = '0;
      m_deb[k] = 2'b00;
      m_mode[k] = 2'd0;
    end
    m_chg = '0;
    sbq.delete();
  endtask

  task automatic mon_start();
    reg_addr = 0;
    tick(2);
    mon_en = 1;
  endtask

  task automatic mon_stop(input string name);
    tick(2);
    mon_en = 0;
    chk(name, sbq.size(), 0);
  endtask

  task automatic run_seq(input int ch, input logic rev);
    logic [1:0] g[5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 1; i < 5; i++) begin
      drive_level(ch, rev ? g[4-i] : g[i]);
      tick(10);
    end
  endtask

  // Scoreboard: every observed change on channel 0's position must match the next prediction
  always @(negedge clk) begin
    if (mon_en && reg_q !== last_q) begin
      if (sbq.size() == 0) chk("sb_spurious", reg_q, last_q);
      else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_pos", reg_q, e.val);
        chk("sb_edge", ecnt, e.edge_n);
      end
    end
    last_q = reg_q;
  end

  initial begin
    vt[0] = '{2'd0, 1'b0, 32'h0004, 32'h01};
    vt[1] = '{2'd0, 1'b1, 32'hFFFC, 32'h01};
    vt[2] = '{2'd1, 1'b0, 32'h0002, 32'h01};
    vt[3] = '{2'd1, 1'b1, 32'hFFFE, 32'h01};
    vt[4] = '{2'd2, 1'b0, 32'h0001, 32'h01};
    vt[5] = '{2'd2, 1'b1, 32'hFFFF, 32'h01};
    vt[6] = '{2'd3, 1'b0, 32'h0000, 32'h00};
    do_reset(2'b00);
    for (int k = 0; k < N; k++) rd("rst_pos", k, 0);
    rd("rst_chg", N, 0);
    rd("rst_mode", N + 1, 0);
    for (int i = 0; i < 7; i++) begin
      do_reset(2'b00);
      wr(N + 1, {30'b0, vt[i].mode}, 4'b0001);
      m_mode[0] = vt[i].mode;
      rd("mode_rb", N + 1, 32'(vt[i].mode));
      mon_start();
      run_seq(0, vt[i].rev);
      mon_stop("seq_drain");
      rd("seq_pos", 0, vt[i].pos);
      rd("seq_chg", N, vt[i].chg);
    end
    do_reset(2'b00);
    mon_start();
    enc_a[0] = 1'b1;
    tick(D - 1);
    enc_a[0] = 1'b0;
    tick(12);
    mon_stop("glitch_short_drain");
    rd("glitch_short_pos", 0, 0);
    rd("glitch_short_chg", N, 0);
    mon_start();
    drive_level(0, 2'b10);
    tick(D);
    drive_level(0, 2'b00);
    tick(14);
    mon_stop("glitch_long_drain");
    rd("glitch_long_pos", 0, 0);
    rd("glitch_long_chg", N, 32'h01);
    do_reset(2'b00);
    mon_start();
    drive_level(0, 2'b11);
    tick(12);
    drive_level(0, 2'b00);
    tick(12);
    mon_stop("invalid_drain");
    rd("invalid_pos", 0, 0);
    rd("invalid_chg", N, 0);
    do_reset(2'b11);
    drive_level(0, 2'b11);
    tick(20);
    rd("rst11_pos", 0, 0);
    rd("rst11_chg", N, 0);
    do_reset(2'b00);
    drive_level(2, 2'b01);
    tick(D + 2);
    wr(2, 32'h0000_1234, 4'b0011);
    m_pos[2] = 16'h1234;
    rd("wr_win_pos", 2, 32'h1234);
    rd("wr_win_chg", N, 32'h04);
    tick(10);
    drive_level(2, 2'b11);
    tick(D + 2);
    wr(N, 32'h4, 4'b0001);
    rd("clr_vs_set_chg", N, 32'h04);
    rd("clr_vs_set_pos", 2, 32'(m_pos[2]));
    wr(N, 32'h4, 4'b0001);
    rd("clr_chg", N, 0);
    wr(2, 32'h0000_AB00, 4'b0010);
    rd("lane1_pos", 2, 32'hAB35);
    wr(2, 32'hFFFF_0000, 4'b1100);
    rd("upper_lanes_pos", 2, 32'hAB35);
    do_reset(2'b00);
    mon_start();
    drive_level(0, 2'b01);
    drive_level(7, 2'b10);
    tick(10);
    drive_level(0, 2'b11);
    drive_level(7, 2'b11);
    tick(10);
    drive_level(0, 2'b10);
    tick(10);
    mon_stop("indep_drain");
    rd("indep_pos0", 0, 32'h0003);
    rd("indep_pos7", 7, 32'hFFFE);
    rd("indep_chg", N, 32'h81);
    rd("unmapped_rd", 10, 0);
    wr(10, 32'hFFFF_FFFF, 4'b1111);
    rd("unmapped_wr_chg", N, 32'h81);
    rd("unmapped_wr_pos0", 0, 32'h0003);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
